md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_step.sv | 37 +++
 rtl/md_unit.sv | 154 +++++++++++++++
 tb/tb_md_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes and FSM encoding.
package md_pkg;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
module md_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] sub;

  always_comb begin
    // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
    addend = lo_i[0] ? m_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    sh     = {hi_i, lo_i[XLEN-1]};
    ge     = sh >= {1'b0, m_i};
    // When ge holds the true difference is below 2^XLEN, so modular width suffices.
    sub    = sh[XLEN-1:0] - m_i;
    if (is_div_i) begin
      hi_o = ge ? sub : sh[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes and kill.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      in_tag,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_tag,
  output logic            busy
);

  localparam int unsigned N    = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [4:0]      tag_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, result_q;
  logic [CntW-1:0] cnt_q;

  logic            accept;
  logic            sa_in, sb_in, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] fix_res;

  assign accept = in_valid && in_ready && !kill;

  // Request decode: sign flags, magnitudes and the directly answered corner cases.
  always_comb begin
    sa_in    = rs1[XLEN-1] && (op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem});
    sb_in    = rs2[XLEN-1] && (op inside {OpMul, OpMulh, OpDiv, OpRem});
    a_mag    = sa_in ? -rs1 : rs1;
    b_mag    = sb_in ? -rs2 : rs2;
    // Remainder sign follows the dividend only.
    neg_in   = (op[2] && op[1]) ? sa_in : (sa_in ^ sb_in);
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == OpDiv) || (op == OpRem)) && (rs1 == MinNeg) && (rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = op[1] ? rs1 : '1;
    end else begin
      special_res = op[1] ? '0 : MinNeg;
    end
  end

  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    md_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div_i(op_q[2]),
      .hi_i    (hi_c[i]),
      .lo_i    (lo_c[i]),
      .m_i     (m_q),
      .hi_o    (hi_c[i+1]),
      .lo_o    (lo_c[i+1])
    );
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_fix, r_fix;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    q_fix  = neg_q ? -lo_q : lo_q;
    r_fix  = neg_q ? -hi_q : hi_q;
    if (!op_q[2]) begin
      fix_res = (op_q == OpMul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else begin
      fix_res = op_q[1] ? r_fix : q_fix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_q == CntW'(N - 1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill) state_d = StIdle;
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      tag_q <= in_tag;
      neg_q <= neg_in;
      hi_q  <= '0;
      lo_q  <= op[2] ? a_mag : b_mag;
      m_q   <= op[2] ? b_mag : a_mag;
      cnt_q <= '0;
      if (special) result_q <= special_res;
    end else if (state_q == StCalc) begin
      hi_q  <= hi_c[BITS_PER_CYCLE];
      lo_q  <= lo_c[BITS_PER_CYCLE];
      cnt_q <= cnt_q + CntW'(1);
    end else if ((state_q == StFix) && !kill) begin
      result_q <= fix_res;
    end
  end

  assign result  = result_q;
  assign out_tag = tag_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, random ops vs. arithmetic model, control corners.
module tb_md_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;
  logic [4:0]  in_tag, out_tag;

  int total = 0;
  int bad   = 0;

  md_unit #(
    .XLEN          (32),
    .BITS_PER_CYCLE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .in_tag   (in_tag),
    .kill     (kill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic definitions, using 64-bit integers.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      MUL:    return a * b;
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        p = sa / sb;
        return p[31:0];
      end
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == DIV || f == REM) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MINV;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, scramble inputs after accept, check latency/result/tag, hold, handshake.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                       input int hold, input string name);
    int lat;
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    op = f; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; in_tag = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result, exp);
    chk({name, " tag"}, 32'(out_tag), 32'(tag));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, " hold result"}, result, exp);
      chk({name, " hold tag"}, 32'(out_tag), 32'(tag));
      chk({name, " hold valid"}, 32'(out_valid), 32'd1);
      chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " post valid"}, 32'(out_valid), 32'd0);
    chk({name, " post in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{MUL,    32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34, "mul neg"};
    vecs[1]  = '{MULH,   MINV,          MINV,          5'd2,  32'h4000_0000, 34, "mulh min"};
    vecs[2]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 34, "mulhu max"};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 34, "mulhsu"};
    vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 34, "div neg"};
    vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFF, 34, "rem neg"};
    vecs[6]  = '{DIVU,   32'd5,         32'd0,         5'd5,  32'hFFFF_FFFF, 1,  "divu by0"};
    vecs[7]  = '{REMU,   32'd5,         32'd0,         5'd6,  32'd5,         1,  "remu by0"};
    vecs[8]  = '{DIV,    MINV,          32'hFFFF_FFFF, 5'd7,  MINV,          1,  "div ovf"};
    vecs[9]  = '{REM,    MINV,          32'hFFFF_FFFF, 5'd8,  32'd0,         1,  "rem ovf"};
    vecs[10] = '{DIVU,   32'd100,       32'd7,         5'd9,  32'd14,        34, "divu"};
    vecs[11] = '{REMU,   32'd100,       32'd7,         5'd10, 32'd2,         34, "remu"};
    vecs[12] = '{DIV,    32'd7,         32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFF9, 34, "div by m1"};
    vecs[13] = '{REM,    32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFF9, 1,  "rem by0"};
    vecs[14] = '{DIV,    32'd9,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  "div by0"};

    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; in_tag = '0;
    tick();
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat, 0,
            vecs[i].name);
    end

    // Backpressure: result held for 5 cycles, handshake on the 6th.
    do_op(MUL, 32'd3, 32'd5, 5'd9, 32'd15, 34, 5, "backpressure");

    // Kill in the 10th CALC cycle.
    op = DIVU; rs1 = 32'd100; rs2 = 32'd7; in_tag = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("kill busy before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill busy", 32'(busy), 32'd0);
    chk("kill in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("kill no out_valid", 32'(seen), 32'd0);

    // Kill together with in_valid in IDLE must not accept.
    op = MUL; rs1 = 32'd2; rs2 = 32'd2; in_tag = 5'd30; in_valid = 1'b1; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    chk("kill+valid busy", 32'(busy), 32'd0);
    tick();
    chk("kill+valid out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in CALC (result and tag are nonzero beforehand).
    op = MUL; rs1 = 32'd6; rs2 = 32'd7; in_tag = 5'd21; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset tag", 32'(out_tag), 32'd21);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst out_tag", 32'(out_tag), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int n = 0; n < 40; n++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      do_op(rf, ra, rb, 5'($urandom), ref_res(rf, ra, rb), ref_lat(rf, ra, rb),
            $urandom_range(0, 2), $sformatf("rand%0d op%0d %h %h", n, rf, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
